instr_dispatch_queue: RTL

- Instruction buffer and dispatcher sitting directly upstream of the PIM control unit.
- Accepts 45-bit PIM instructions from the host with a valid/ready handshake and stores them in a FIFO.
- Issues them one at a time to the control unit using that unit's operation_enable/ready handshake, and reports completion back to the host.

---
 rtl/pim_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 47 ++++
 rtl/instr_dispatch_queue.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pim_pkg.sv
// Shared PIM definitions: instruction width, field positions and dispatch FSM states.
package pim_pkg;

  localparam int INSTR_W = 45;
  localparam int ALU_BIT = 44;
  localparam int OP_HI   = 43;
  localparam int OP_LO   = 42;
  localparam int A_MSB   = 41;
  localparam int A_LSB   = 32;
  localparam int B_MSB   = 31;
  localparam int B_LSB   = 22;
  localparam int C_MSB   = 21;
  localparam int C_LSB   = 12;
  localparam int IMM_W   = 32;
  localparam int ADDR_W  = 10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } dispatch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Power-of-two FIFO with combinational head so the dispatcher can load and pop on one edge.
module sync_fifo #(
  parameter int WIDTH = 45,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;

  // Storage is not reset; entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/instr_dispatch_queue.sv
// Buffers host PIM instructions and issues them one at a time to the control unit.
// Optional saturating statistics outputs are enabled by INSTR_DISPATCH_STATS_EN.
module instr_dispatch_queue
  import pim_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_W-1:0]     in_instruction,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [INSTR_W-1:0]     cu_instruction,
  output logic                   cu_operation_enable,
  input  logic                   cu_ready,
  output logic                   done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fill_count,
`ifdef INSTR_DISPATCH_STATS_EN
  output logic [15:0]            issued_count,
  output logic [15:0]            alu_count,
  output logic [$clog2(DEPTH):0] max_fill,
`endif
  output logic                   ack_error
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 2);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [TW-1:0] TIMEOUT_C = TW'(ACK_TIMEOUT);

  logic               push;
  logic               pop;
  logic [INSTR_W-1:0] head;
  logic [CW-1:0]      count;

  dispatch_state_t    state_reg, state_next;
  logic [TW-1:0]      timer_reg, timer_next;
  logic [INSTR_W-1:0] cu_instr_reg, cu_instr_next;
  logic               op_en_reg, op_en_next;
  logic               done_reg, done_next;
  logic               ack_err_reg, ack_err_next;

  assign in_ready = (count < DEPTH_C);
  assign push     = in_valid && in_ready;

  sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (in_instruction),
    .head    (head),
    .count   (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      cu_instr_reg <= '0;
      op_en_reg    <= 1'b0;
      done_reg     <= 1'b0;
      ack_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      cu_instr_reg <= cu_instr_next;
      op_en_reg    <= op_en_next;
      done_reg     <= done_next;
      ack_err_reg  <= ack_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    cu_instr_next = cu_instr_reg;
    op_en_next    = 1'b0;
    done_next     = 1'b0;
    ack_err_next  = ack_err_reg;
    pop           = 1'b0;
    case (state_reg)
      IDLE: begin
        if ((count != '0) && cu_ready) begin
          pop           = 1'b1;
          cu_instr_next = head;
          op_en_next    = 1'b1;
          state_next    = ISSUE;
        end
      end
      ISSUE: begin
        timer_next = '0;
        state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        // A control unit that never drops ready did not take the instruction; drop it.
        if (!cu_ready) begin
          state_next = WAIT_DONE;
        end else if (timer_reg == TIMEOUT_C) begin
          ack_err_next = 1'b1;
          state_next   = IDLE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (cu_ready) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign cu_instruction      = cu_instr_reg;
  assign cu_operation_enable = op_en_reg;
  assign done                = done_reg;
  assign ack_error           = ack_err_reg;
  assign fill_count          = count;
  assign busy                = (count != '0) || (state_reg != IDLE);

`ifdef INSTR_DISPATCH_STATS_EN
  logic [15:0]   issued_reg;
  logic [15:0]   alu_reg;
  logic [CW-1:0] max_fill_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_reg   <= '0;
      alu_reg      <= '0;
      max_fill_reg <= '0;
    end else begin
      if (pop && (issued_reg != 16'hFFFF))
        issued_reg <= issued_reg + 16'd1;
      if (pop && head[ALU_BIT] && (alu_reg != 16'hFFFF))
        alu_reg <= alu_reg + 16'd1;
      if (count > max_fill_reg)
        max_fill_reg <= count;
    end
  end

  assign issued_count = issued_reg;
  assign alu_count    = alu_reg;
  assign max_fill     = max_fill_reg;
`endif

endmodule
